oven_input_conditioner: RTL
===========================

Name: oven_input_conditioner

Overview:
- Front-end stage that directly feeds the oven controller's A–E control inputs.
- Takes raw asynchronous switch/button levels and, per channel, synchronizes them into clk, debounces them, and produces three outputs:
  - a clean level;
  - a one-cycle press pulse, with optional auto-repeat while held;
  - a one-cycle release pulse.
- The controller consumes these levels and pulses for mode selection and for temperature/time increment and decrement, instead of sampling raw inputs on its slow clock.

Parameters:
- NUM_BTN, 5: number of independent input channels (A..E).
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples required to accept a change (20 ms at 50 MHz). Must be ≥ 2.
- REPEAT_DELAY, 25000000: cycles a press must be held before the first auto-repeat pulse (0.5 s).
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses (0.2 s).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  NUM_BTN  raw active-high inputs, asynchronous to clk.
- btn_level  out  NUM_BTN  debounced level.
- btn_press  out  NUM_BTN  one-cycle pulse on accepted press (and on auto-repeat).
- btn_release  out  NUM_BTN  one-cycle pulse on accepted release.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, synchronizers 0, every channel in IDLE, all counters 0. Behaviour after deassertion is synchronous.
- Synchronizer: two-flop chain per channel. The synchronized value s lags btn_raw by 2 clk edges.
- Channels are fully independent; simultaneous activity on any number of channels is legal.
- Per-channel FSM, states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE (level 0): s=1 → PRESS_WAIT, debounce counter cleared.
  - PRESS_WAIT:
    - counter increments each cycle s=1;
    - s=0 → IDLE (glitch rejected, no pulse);
    - on the DEBOUNCE_CYCLES-th consecutive s=1 sample → HELD; level←1, press pulse for 1 cycle, repeat counter cleared.
  - HELD (level 1):
    - s=0 → RELEASE_WAIT, debounce counter cleared;
    - the repeat counter keeps running but does not fire while outside HELD.
  - RELEASE_WAIT:
    - s=1 → HELD (glitch rejected; level stays 1, no pulses, repeat counter not cleared);
    - DEBOUNCE_CYCLES consecutive s=0 → IDLE; level←0, release pulse for 1 cycle.
- Latency: a clean raw edge produces its pulse/level change exactly DEBOUNCE_CYCLES+2 clk edges after the first rising edge that samples the new value. All outputs are registered.
- Counter widths: $clog2 of the largest parameter value + 1. Counters saturate; they never wrap.
- btn_press and btn_release for one channel are never both 1 in the same cycle.

Optional Feature:
- Macro OVEN_AUTO_REPEAT_EN.
- Defined:
  - in HELD, a press pulse fires when the repeat counter reaches REPEAT_DELAY;
  - it then fires every REPEAT_PERIOD cycles while the channel stays in HELD;
  - the counter is cleared on entry to HELD from PRESS_WAIT.
- Undefined: no repeat counter is instantiated; exactly one press pulse per accepted press. REPEAT_* parameters are ignored.

Decomposition:
- Package oven_pkg holds:
  - the FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - default timing constants;
  - channel index constants BTN_A..BTN_E (0..4), shared with the controller.
- Sub-module oven_debounce_channel contains one synchronizer, FSM and counters. The top generates NUM_BTN instances.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset mid-operation:
  - stimulus: assert rst_n=0 while channel 0 is HELD with level 1;
  - response: level/press/release go 0 immediately with no clock edge; after release, raw held high yields a fresh press 6 cycles later.
- Clean press:
  - stimulus: raw[0] 0→1 and held;
  - response: press[0] high for exactly 1 cycle, 6 edges after the first high sample; level[0]=1 from the same edge; other channels stay 0.
- Glitch rejection:
  - stimulus: raw[1] high for 3 cycles, then low;
  - response: no press, level stays 0. A 3-cycle low dip while HELD: no release, level stays 1.
- Clean release:
  - stimulus: raw[0] 1→0 after HELD;
  - response: release[0] 1-cycle pulse 6 edges later; level[0]=0.
- Simultaneous channels:
  - stimulus: raw[4:0]=5'b10101 at the same edge;
  - response: press pulses on channels 0, 2, 4 in the same cycle; channels 1 and 3 stay 0.
- Auto-repeat with macro defined:
  - stimulus: hold raw[2] high 30 cycles after acceptance;
  - response: press pulses at acceptance and at +10, +13, +16, +19, +22, +25, +28 cycles.
  - Without the macro: exactly one pulse.

Source files
------------

// File: rtl/oven_pkg.sv
// Shared definitions for the oven front end: channel FSM states, default timing,
// and channel indices used by both this block and the oven controller.
package oven_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_e;

  localparam int unsigned DEF_NUM_BTN         = 5;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;  // 0.2 s

  localparam int unsigned BTN_A = 0;
  localparam int unsigned BTN_B = 1;
  localparam int unsigned BTN_C = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_E = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/oven_debounce_channel.sv
// One input channel: 2-flop synchronizer, debounce FSM, registered level/press/release.
// Auto-repeat of the press pulse is built only when OVEN_AUTO_REPEAT_EN is defined.
module oven_debounce_channel
  import oven_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          s;
  logic [CW-1:0] cnt_inc;

  assign s       = sync_q[1];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

`ifdef OVEN_AUTO_REPEAT_EN
  logic [CW-1:0] rpt_q, rpt_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] rpt_sat;
  logic [CW-1:0] rpt_target;

  // The repeat counter free-runs (saturating) in every state; phase selects
  // whether the next pulse is the initial delay or a periodic repeat.
  assign rpt_sat    = (rpt_q == '1) ? rpt_q : rpt_q + CW'(1);
  assign rpt_target = phase_q ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      phase_q <= phase_d;
    end
  end
`endif

  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
`ifdef OVEN_AUTO_REPEAT_EN
    rpt_d   = rpt_sat;
    phase_d = phase_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q >= DB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
`ifdef OVEN_AUTO_REPEAT_EN
          rpt_d   = '0;
          phase_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef OVEN_AUTO_REPEAT_EN
        else if (rpt_sat >= rpt_target) begin
          press_d = 1'b1;
          rpt_d   = '0;
          phase_d = 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
        end else if (cnt_q >= DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/oven_input_conditioner.sv
// Conditions the raw A..E oven inputs into clean levels and press/release pulses.
// Optional auto-repeat of press pulses: define OVEN_AUTO_REPEAT_EN.
module oven_input_conditioner
  import oven_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    oven_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end

endmodule
